bnn_load_sequencer: RTL and testbench

Phase sequencer between the BNN accelerator's pad-side input interface and its internal buffers and compute engines. It accepts the 16-bit input word stream and steers it in a fixed order:

- conv1 weights, then the input feature map;
- it then launches the convolution;
- it then feeds the FC weights one output-neuron group at a time under a ready handshake;
- finally it presents the 4-bit class label with the pad output enable.

It owns the whole per-image schedule; the datapath only reports completion.

---
 rtl/bnn_load_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_bnn_load_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_load_sequencer.sv
// rtl/bnn_load_sequencer.sv - per-image load/compute phase sequencer for the BNN accelerator
module bnn_load_sequencer #(
    parameter int CW_WORDS  = 6,
    parameter int MAP_WORDS = 136,
    parameter int FC_WORDS  = 6,
    parameter int FC_GROUPS = 10,
    parameter int OUT_HOLD  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mode_i,
    input  logic        in_valid_i,
    input  logic [15:0] data_i,
    input  logic        conv_done_i,
    input  logic        fc_grp_done_i,
    input  logic        result_valid_i,
    input  logic [3:0]  result_label_i,
    output logic        in_ready_o,
    output logic [15:0] wr_data_o,
    output logic        cw_we_o,
    output logic [2:0]  cw_addr_o,
    output logic        map_we_o,
    output logic [7:0]  map_addr_o,
    output logic        fc_we_o,
    output logic [2:0]  fc_addr_o,
    output logic [3:0]  fc_grp_o,
    output logic        conv_start_o,
    output logic        fc_start_o,
    output logic        out_en_o,
    output logic [3:0]  label_out_o,
    output logic        proto_err_o
);

    typedef enum logic [2:0] {
        S_LOAD_CW,
        S_LOAD_MAP,
        S_CONV,
        S_FC_LOAD,
        S_FC_RUN,
        S_RESULT,
        S_OUT
    } state_t;

    // Last index of each counted phase, sized to the shared phase counter.
    localparam logic [7:0] CW_LAST  = 8'(CW_WORDS - 1);
    localparam logic [7:0] MAP_LAST = 8'(MAP_WORDS - 1);
    localparam logic [7:0] FC_LAST  = 8'(FC_WORDS - 1);
    localparam logic [7:0] OUT_LAST = 8'(OUT_HOLD - 1);
    localparam logic [3:0] GRP_LAST = 4'(FC_GROUPS - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        in_ready_q;
    logic [15:0] wr_data_q;
    logic        cw_we_q;
    logic [2:0]  cw_addr_q;
    logic        map_we_q;
    logic [7:0]  map_addr_q;
    logic        fc_we_q;
    logic [2:0]  fc_addr_q;
    logic [3:0]  fc_grp_q;
    logic        conv_start_q;
    logic        fc_start_q;
    logic        out_en_q;
    logic [3:0]  label_q;
    logic        proto_err_q;

    logic        mode_ok_d;
    logic        accept_d;
    logic        mode_err_d;

    // The map phase takes map-type words; every other load phase takes weights.
    // in_ready_q is only ever high in a load state, so it gates both outcomes.
    assign mode_ok_d  = (state_q == S_LOAD_MAP) ? ~mode_i : mode_i;
    assign accept_d   = in_ready_q & in_valid_i & mode_ok_d;
    assign mode_err_d = in_ready_q & in_valid_i & ~mode_ok_d;

    // Phase FSM with all outputs registered; write strobes and starts are single-cycle pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_LOAD_CW;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            wr_data_q    <= '0;
            cw_we_q      <= 1'b0;
            cw_addr_q    <= '0;
            map_we_q     <= 1'b0;
            map_addr_q   <= '0;
            fc_we_q      <= 1'b0;
            fc_addr_q    <= '0;
            fc_grp_q     <= '0;
            conv_start_q <= 1'b0;
            fc_start_q   <= 1'b0;
            out_en_q     <= 1'b0;
            label_q      <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            cw_we_q      <= 1'b0;
            map_we_q     <= 1'b0;
            fc_we_q      <= 1'b0;
            conv_start_q <= 1'b0;
            fc_start_q   <= 1'b0;

            if (mode_err_d) begin
                proto_err_q <= 1'b1;
            end
            if (accept_d) begin
                wr_data_q <= data_i;
            end

            case (state_q)
                S_LOAD_CW: begin
                    // Also raises in_ready the first cycle after reset.
                    in_ready_q <= 1'b1;
                    if (accept_d) begin
                        cw_we_q   <= 1'b1;
                        cw_addr_q <= cnt_q[2:0];
                        if (cnt_q == CW_LAST) begin
                            cnt_q   <= '0;
                            state_q <= S_LOAD_MAP;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                S_LOAD_MAP: begin
                    if (accept_d) begin
                        map_we_q   <= 1'b1;
                        map_addr_q <= cnt_q;
                        if (cnt_q == MAP_LAST) begin
                            cnt_q        <= '0;
                            in_ready_q   <= 1'b0;
                            conv_start_q <= 1'b1;
                            state_q      <= S_CONV;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                S_CONV: begin
                    // A done pulse coincident with our own start pulse is stale.
                    if (conv_done_i && !conv_start_q) begin
                        fc_grp_q   <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        state_q    <= S_FC_LOAD;
                    end
                end
                S_FC_LOAD: begin
                    if (accept_d) begin
                        fc_we_q   <= 1'b1;
                        fc_addr_q <= cnt_q[2:0];
                        if (cnt_q == FC_LAST) begin
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            fc_start_q <= 1'b1;
                            state_q    <= S_FC_RUN;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                S_FC_RUN: begin
                    if (fc_grp_done_i && !fc_start_q) begin
                        if (fc_grp_q == GRP_LAST) begin
                            state_q <= S_RESULT;
                        end else begin
                            fc_grp_q   <= fc_grp_q + 4'd1;
                            cnt_q      <= '0;
                            in_ready_q <= 1'b1;
                            state_q    <= S_FC_LOAD;
                        end
                    end
                end
                S_RESULT: begin
                    if (result_valid_i) begin
                        label_q  <= result_label_i;
                        out_en_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= S_OUT;
                    end
                end
                S_OUT: begin
                    // cnt counts the hold cycles already spent on the pads.
                    if (cnt_q == OUT_LAST) begin
                        out_en_q   <= 1'b0;
                        cnt_q      <= '0;
                        fc_grp_q   <= '0;
                        in_ready_q <= 1'b1;
                        state_q    <= S_LOAD_CW;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    in_ready_q <= 1'b0;
                    state_q    <= S_LOAD_CW;
                end
            endcase
        end
    end

    assign in_ready_o   = in_ready_q;
    assign wr_data_o    = wr_data_q;
    assign cw_we_o      = cw_we_q;
    assign cw_addr_o    = cw_addr_q;
    assign map_we_o     = map_we_q;
    assign map_addr_o   = map_addr_q;
    assign fc_we_o      = fc_we_q;
    assign fc_addr_o    = fc_addr_q;
    assign fc_grp_o     = fc_grp_q;
    assign conv_start_o = conv_start_q;
    assign fc_start_o   = fc_start_q;
    assign out_en_o     = out_en_q;
    assign label_out_o  = label_q;
    assign proto_err_o  = proto_err_q;

endmodule

// File: tb/tb_bnn_load_sequencer.sv
// tb/tb_bnn_load_sequencer.sv - randomized bench with image-level reference model for bnn_load_sequencer
module tb_bnn_load_sequencer;

    localparam int CW     = 6;
    localparam int MAP    = 136;
    localparam int FC     = 6;
    localparam int GROUPS = 10;
    localparam int HOLD   = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        mode_i;
    logic        in_valid_i;
    logic [15:0] data_i;
    logic        conv_done_i;
    logic        fc_grp_done_i;
    logic        result_valid_i;
    logic [3:0]  result_label_i;
    logic        in_ready_o;
    logic [15:0] wr_data_o;
    logic        cw_we_o;
    logic [2:0]  cw_addr_o;
    logic        map_we_o;
    logic [7:0]  map_addr_o;
    logic        fc_we_o;
    logic [2:0]  fc_addr_o;
    logic [3:0]  fc_grp_o;
    logic        conv_start_o;
    logic        fc_start_o;
    logic        out_en_o;
    logic [3:0]  label_out_o;
    logic        proto_err_o;

    always #5 clk = ~clk;

    bnn_load_sequencer dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .mode_i         (mode_i),
        .in_valid_i     (in_valid_i),
        .data_i         (data_i),
        .conv_done_i    (conv_done_i),
        .fc_grp_done_i  (fc_grp_done_i),
        .result_valid_i (result_valid_i),
        .result_label_i (result_label_i),
        .in_ready_o     (in_ready_o),
        .wr_data_o      (wr_data_o),
        .cw_we_o        (cw_we_o),
        .cw_addr_o      (cw_addr_o),
        .map_we_o       (map_we_o),
        .map_addr_o     (map_addr_o),
        .fc_we_o        (fc_we_o),
        .fc_addr_o      (fc_addr_o),
        .fc_grp_o       (fc_grp_o),
        .conv_start_o   (conv_start_o),
        .fc_start_o     (fc_start_o),
        .out_en_o       (out_en_o),
        .label_out_o    (label_out_o),
        .proto_err_o    (proto_err_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Image-level model: the whole image is one word stream indexed by m_n;
    // phase, address and group all follow from that index and the completion events seen.
    int          m_n, m_grps, m_out_left;
    bit          m_conv_fin;
    bit          e_in_ready, e_cw_we, e_map_we, e_fc_we, e_conv_start, e_fc_start, e_out_en, e_err;
    int          e_cw_addr, e_map_addr, e_fc_addr, e_fc_grp;
    logic [15:0] e_wr_data;
    logic [3:0]  e_label;

    function automatic logic want_weight(input int n);
        return (n < CW) || (n >= CW + MAP);
    endfunction

    function automatic bit load_allowed();
        if (m_out_left > 0) return 1'b0;
        if (m_n < CW + MAP) return 1'b1;
        return m_conv_fin && (m_grps < GROUPS) && (m_n < CW + MAP + FC * (m_grps + 1));
    endfunction

    task automatic model_reset();
        m_n = 0; m_grps = 0; m_out_left = 0; m_conv_fin = 0;
        e_in_ready = 0; e_cw_we = 0; e_map_we = 0; e_fc_we = 0;
        e_conv_start = 0; e_fc_start = 0; e_out_en = 0; e_err = 0;
        e_cw_addr = 0; e_map_addr = 0; e_fc_addr = 0; e_fc_grp = 0;
        e_wr_data = '0; e_label = '0;
    endtask

    task automatic model_step();
        bit cs, fs, wc, wf, wr, wo, acc;
        if (rst_i) begin
            model_reset();
            return;
        end
        cs = e_conv_start;
        fs = e_fc_start;
        wc = (m_n == CW + MAP) && !m_conv_fin;
        wf = m_conv_fin && (m_grps < GROUPS) && (m_n == CW + MAP + FC * (m_grps + 1));
        wr = (m_grps == GROUPS) && (m_out_left == 0);
        wo = (m_out_left > 0);
        e_cw_we = 0; e_map_we = 0; e_fc_we = 0; e_conv_start = 0; e_fc_start = 0;
        acc = 0;
        if (e_in_ready && in_valid_i) begin
            if (mode_i == want_weight(m_n)) acc = 1;
            else e_err = 1;
        end
        if (acc) begin
            if (m_n < CW) begin
                e_cw_we = 1; e_cw_addr = m_n;
            end else if (m_n < CW + MAP) begin
                e_map_we = 1; e_map_addr = m_n - CW;
            end else begin
                e_fc_we = 1; e_fc_addr = (m_n - CW - MAP) % FC;
            end
            e_wr_data = data_i;
            m_n++;
            if (m_n == CW + MAP) e_conv_start = 1;
            else if (m_n > CW + MAP && (m_n - CW - MAP) % FC == 0) e_fc_start = 1;
        end else if (wc && conv_done_i && !cs) begin
            m_conv_fin = 1;
        end else if (wf && fc_grp_done_i && !fs) begin
            m_grps++;
        end else if (wr && result_valid_i) begin
            e_label = result_label_i;
            m_out_left = HOLD;
        end else if (wo) begin
            m_out_left--;
            if (m_out_left == 0) begin
                m_n = 0; m_grps = 0; m_conv_fin = 0;
            end
        end
        e_out_en   = (m_out_left > 0);
        e_fc_grp   = (m_grps > GROUPS - 1) ? GROUPS - 1 : m_grps;
        e_in_ready = load_allowed();
    endtask

    // Cumulative observations of the DUT, used for the per-image literal checks.
    int         s_cw, s_cw_sum, s_map, s_map_breaks, s_cs, s_fs, s_fs_sum, s_out;
    int         s_prev_map;
    logic [3:0] s_last_label;

    // Single compare process: check outputs mid-cycle, then advance the model by the coming edge.
    initial begin
        model_reset();
        s_cw = 0; s_cw_sum = 0; s_map = 0; s_map_breaks = 0; s_cs = 0; s_fs = 0;
        s_fs_sum = 0; s_out = 0; s_prev_map = -1; s_last_label = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("in_ready", in_ready_o, e_in_ready);
            chk("wr_data", wr_data_o, e_wr_data);
            chk("cw_we", cw_we_o, e_cw_we);
            chk("cw_addr", cw_addr_o, e_cw_addr);
            chk("map_we", map_we_o, e_map_we);
            chk("map_addr", map_addr_o, e_map_addr);
            chk("fc_we", fc_we_o, e_fc_we);
            chk("fc_addr", fc_addr_o, e_fc_addr);
            chk("fc_grp", fc_grp_o, e_fc_grp);
            chk("conv_start", conv_start_o, e_conv_start);
            chk("fc_start", fc_start_o, e_fc_start);
            chk("out_en", out_en_o, e_out_en);
            chk("label_out", label_out_o, e_label);
            chk("proto_err", proto_err_o, e_err);
            if (cw_we_o) begin s_cw++; s_cw_sum += int'(cw_addr_o); end
            if (map_we_o) begin
                s_map++;
                if (!(map_addr_o == 0 || int'(map_addr_o) == s_prev_map + 1)) s_map_breaks++;
                s_prev_map = int'(map_addr_o);
            end
            if (conv_start_o) s_cs++;
            if (fc_start_o) begin s_fs++; s_fs_sum += int'(fc_grp_o); end
            if (out_en_o) begin s_out++; s_last_label = label_out_o; end
            model_step();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap();
        in_valid_i = 1'b0;
        repeat ($urandom_range(0, 2)) cyc();
    endtask

    // Present one word and hold it until the DUT shows in_ready for that cycle.
    task automatic send_word(input logic m);
        bit ok;
        ok = 0;
        mode_i     = m;
        data_i     = 16'($urandom);
        in_valid_i = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (in_ready_o) begin
                ok = 1;
                cyc();
                break;
            end
            cyc();
        end
        in_valid_i = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL word_handshake: got in_ready 0 expected 1 within 60 cycles at %0t", $time);
        end
    endtask

    // One image; returns early (after a one-cycle rst) when abort_at names a map word index.
    task automatic run_image(input logic [3:0] label, input bit mis, input bit strays, input int abort_at);
        int b_cw, b_cw_sum, b_map, b_cs, b_fs, b_fs_sum, b_out;
        b_cw = s_cw; b_cw_sum = s_cw_sum; b_map = s_map; b_cs = s_cs;
        b_fs = s_fs; b_fs_sum = s_fs_sum; b_out = s_out;
        for (int i = 0; i < CW; i++) begin
            if (mis && i == 3) send_word(1'b0);
            send_word(1'b1);
        end
        for (int i = 0; i < MAP; i++) begin
            idle_gap();
            if (strays && i == 50) begin
                conv_done_i = 1'b1;
                cyc();
                conv_done_i = 1'b0;
            end
            if (i == abort_at) begin
                rst_i = 1'b1;
                cyc();
                rst_i = 1'b0;
                return;
            end
            send_word(1'b0);
        end
        for (int t = 0; t < 5; t++) begin
            conv_done_i = strays && (t == 0);
            in_valid_i  = strays && (t < 3);
            mode_i      = 1'($urandom);
            cyc();
        end
        in_valid_i  = 1'b0;
        conv_done_i = 1'b1;
        cyc();
        conv_done_i = 1'b0;
        for (int g = 0; g < GROUPS; g++) begin
            for (int w = 0; w < FC; w++) begin
                idle_gap();
                send_word(1'b1);
            end
            for (int t = 0; t < 3; t++) begin
                fc_grp_done_i = strays && (t == 0);
                in_valid_i    = strays && (t < 2);
                mode_i        = 1'($urandom);
                cyc();
            end
            in_valid_i    = 1'b0;
            fc_grp_done_i = 1'b1;
            cyc();
            fc_grp_done_i = 1'b0;
        end
        cyc();
        cyc();
        result_valid_i = 1'b1;
        result_label_i = label;
        cyc();
        result_valid_i = 1'b0;
        result_label_i = 4'($urandom);
        repeat (6) cyc();
        chk("img_cw_writes", s_cw - b_cw, CW);
        chk("img_cw_addr_sum", s_cw_sum - b_cw_sum, 15);
        chk("img_map_writes", s_map - b_map, MAP);
        chk("img_conv_starts", s_cs - b_cs, 1);
        chk("img_fc_starts", s_fs - b_fs, GROUPS);
        chk("img_fc_grp_sum", s_fs_sum - b_fs_sum, 45);
        chk("img_out_cycles", s_out - b_out, HOLD);
        chk("img_label", s_last_label, label);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int b_cs, b_out;
        rst_i = 1'b1; mode_i = 1'b0; in_valid_i = 1'b0; data_i = '0;
        conv_done_i = 1'b0; fc_grp_done_i = 1'b0; result_valid_i = 1'b0; result_label_i = '0;
        cyc();
        cyc();
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_wr_data", wr_data_o, 0);
        chk("rst_label", label_out_o, 0);
        chk("rst_proto_err", proto_err_o, 0);
        rst_i = 1'b0;
        cyc();
        chk("in_ready_after_rst", in_ready_o, 1);

        run_image(4'd7, 1'b0, 1'b1, -1);
        chk("proto_err_clean_image", proto_err_o, 0);

        run_image(4'd5, 1'b1, 1'b0, -1);
        chk("proto_err_sticky", proto_err_o, 1);

        b_cs = s_cs;
        run_image(4'd2, 1'b0, 1'b0, 70);
        chk("proto_err_after_rst", proto_err_o, 0);
        run_image(4'd6, 1'b0, 1'b0, -1);
        chk("abort_conv_starts", s_cs - b_cs, 1);
        chk("map_contiguous", s_map_breaks, 0);

        b_out = s_out;
        run_image(4'd3, 1'b0, 1'b1, -1);
        run_image(4'd9, 1'b0, 1'b0, -1);
        chk("two_image_out_cycles", s_out - b_out, 2 * HOLD);

        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
